mem_port_arbiter: RTL and testbench

- Shares one single-port block RAM between the instruction-fetch requester and the data-memory (MA) requester.
- Sits between the IF/MA units and the BRAM; replaces the separate IM/DM BRAM ports with one arbitrated port.
- Serialises transactions with a level-request / single-cycle-done handshake, matching the DMdone-style stall interface.
- DM has priority; a streak limit guarantees instruction fetch forward progress.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port BRAM arbiter.
// Holds the FSM and owner encodings plus default bus widths.
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 7;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port BRAM between instruction fetch and data memory.
// DM wins by default; a streak limit lets a waiting fetch through.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW            = DEF_AW,
  parameter int DW            = DEF_DW,
  parameter int RD_LAT        = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_clka,
  output logic          mem_ena,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addra,
  output logic [DW-1:0] mem_dina,
  input  logic [DW-1:0] mem_douta
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    lat_q, lat_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;

  logic if_el, dm_el, grant_dm, grant_if;

  // A requester is ignored during its own done cycle
  assign if_el    = if_req & ~if_done_q;
  assign dm_el    = dm_req & ~dm_done_q;
  assign grant_dm = dm_el & (~if_el | (streak_q != STREAK_MAX));
  assign grant_if = if_el & ~grant_dm;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!dm_req) streak_d = '0;
        if (grant_dm) begin
          owner_d = OWN_DM;
          addr_d  = dm_addr;
          we_d    = dm_we;
          wdata_d = dm_wdata;
          state_d = ST_ISSUE;
          if (streak_q != STREAK_MAX)
            streak_d = streak_q + SW'(1);
        end else if (grant_if) begin
          owner_d  = OWN_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          state_d  = ST_ISSUE;
          streak_d = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        lat_d   = 3'd1;
      end
      ST_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = ST_IDLE;
          lat_d   = 3'd0;
          owner_d = OWN_NONE;
          if (owner_q == OWN_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_douta;
          end else if (owner_q == OWN_DM) begin
            dm_done_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_douta;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      lat_q      <= 3'd0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
    end
  end

  assign mem_clka  = clk;
  assign mem_ena   = (state_q == ST_ISSUE);
  assign mem_wea   = (state_q == ST_ISSUE) & we_q;
  assign mem_addra = addr_q;
  assign mem_dina  = wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter, two lanes (RD_LAT 1 and 3).
// A transaction-level model predicts grants, bus activity and done timing.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          who;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          iss;
    int          dn;
  } txn_t;

  for (genvar L = 0; L < 2; L++) begin : g_lane
    localparam int LAT  = (L == 0) ? 1 : 3;
    localparam int MAXS = (L == 0) ? 4 : 2;

    logic          rst, if_req, if_done, dm_req, dm_we, dm_done;
    logic          mem_clka, mem_ena, mem_wea;
    logic [AW-1:0] if_addr, dm_addr, mem_addra;
    logic [DW-1:0] if_rdata, dm_rdata, dm_wdata, mem_dina, mem_douta;
    logic          fin = 1'b0;

    mem_port_arbiter #(
      .AW(AW), .DW(DW), .RD_LAT(LAT), .MAX_DM_STREAK(MAXS)
    ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .if_done(if_done), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
      .mem_clka(mem_clka), .mem_ena(mem_ena), .mem_wea(mem_wea),
      .mem_addra(mem_addra), .mem_dina(mem_dina),
      .mem_douta(mem_douta)
    );

    // BRAM: read data valid only in the cycle it is due, junk otherwise
    logic [DW-1:0] bmem [128];
    logic [DW-1:0] mmem [128];
    logic          pv [4];
    logic [DW-1:0] pd [4];
    logic [DW-1:0] junk;

    initial begin
      for (int i = 0; i < 128; i++) begin
        logic [31:0] v;
        v = $urandom;
        bmem[i] = v;
        mmem[i] = v;
      end
      bmem[5] = 32'hDEADBEEF;
      mmem[5] = 32'hDEADBEEF;
    end

    always @(posedge clk) begin
      if (mem_ena && mem_wea) bmem[mem_addra] <= mem_dina;
      for (int i = 3; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= mem_ena && !mem_wea;
      pd[0] <= bmem[mem_addra];
      junk  <= $urandom;
    end

    assign mem_douta = pv[LAT-1] ? pd[LAT-1] : junk;

    // Reference model: one transaction at a time, busy until its done cycle
    txn_t        q[$];
    int          cyc = 0;
    int          next_eval = 0;
    int          last_dn = -1;
    int          last_who = 0;
    int          streak = 0;
    bit          started = 0;
    logic [31:0] exp_ifr = 0;
    logic [31:0] exp_dmr = 0;

    always @(posedge clk) begin : model
      bit   ie, de;
      txn_t t;
      if (rst) begin
        q.delete();
        streak    = 0;
        next_eval = cyc + 1;
        last_dn   = -1;
        exp_ifr   = 0;
        exp_dmr   = 0;
        started   = 1;
      end else if (started && cyc >= next_eval) begin
        ie = if_req && !(last_dn == cyc && last_who == 1);
        de = dm_req && !(last_dn == cyc && last_who == 2);
        t.who = 0;
        if (de && (!ie || streak < MAXS)) begin
          t.who = 2;
          if (streak < MAXS) streak = streak + 1;
        end else if (ie) begin
          t.who = 1;
          streak = 0;
        end else if (!dm_req) begin
          streak = 0;
        end
        if (t.who != 0) begin
          t.we    = (t.who == 2) && dm_we;
          t.addr  = (t.who == 2) ? dm_addr : if_addr;
          t.wdata = dm_wdata;
          t.rd    = mmem[t.addr];
          if (t.we) mmem[t.addr] = t.wdata;
          t.iss     = cyc + 1;
          t.dn      = cyc + LAT + 2;
          last_dn   = t.dn;
          last_who  = t.who;
          next_eval = t.dn;
          q.push_back(t);
        end
      end
      cyc++;
    end

    always @(negedge clk) begin : monitor
      bit   xi, xd, xe;
      txn_t t;
      if (started) begin
        xi = 0;
        xd = 0;
        xe = 0;
        if (q.size() > 0 && q[0].iss == cyc) begin
          xe = 1;
          check($sformatf("L%0d mem_addra", L), 32'(mem_addra), 32'(q[0].addr));
          check($sformatf("L%0d mem_wea", L), 32'(mem_wea), 32'(q[0].we));
          if (q[0].we)
            check($sformatf("L%0d mem_dina", L), mem_dina, q[0].wdata);
        end else begin
          check($sformatf("L%0d mem_wea idle", L), 32'(mem_wea), 32'(0));
        end
        check($sformatf("L%0d mem_ena", L), 32'(mem_ena), 32'(xe));
        if (q.size() > 0 && q[0].dn == cyc) begin
          t = q.pop_front();
          if (t.who == 1) begin
            xi = 1;
            exp_ifr = t.rd;
          end else begin
            xd = 1;
            if (!t.we) exp_dmr = t.rd;
          end
        end
        check($sformatf("L%0d if_done c%0d", L, cyc), 32'(if_done), 32'(xi));
        check($sformatf("L%0d dm_done c%0d", L, cyc), 32'(dm_done), 32'(xd));
        check($sformatf("L%0d if_rdata", L), if_rdata, exp_ifr);
        check($sformatf("L%0d dm_rdata", L), dm_rdata, exp_dmr);
      end
    end

    task automatic do_if(input logic [AW-1:0] a);
      int n;
      if_req  = 1'b1;
      if_addr = a;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!if_done && n < 100);
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL L%0d if_done timeout: got none expected pulse", L);
      end
      if_req = 1'b0;
    endtask

    task automatic do_dm(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
      int n;
      dm_req   = 1'b1;
      dm_we    = w;
      dm_addr  = a;
      dm_wdata = d;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!dm_done && n < 100);
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL L%0d dm_done timeout: got none expected pulse", L);
      end
      dm_req = 1'b0;
    endtask

    initial begin : stim
      int n;
      rst = 1'b1;
      if_req = 1'b0;
      dm_req = 1'b0;
      dm_we = 1'b0;
      if_addr = '0;
      dm_addr = '0;
      dm_wdata = '0;
      repeat (3) @(negedge clk);
      check($sformatf("L%0d rst if_done", L), 32'(if_done), 32'(0));
      check($sformatf("L%0d rst dm_done", L), 32'(dm_done), 32'(0));
      check($sformatf("L%0d rst mem_ena", L), 32'(mem_ena), 32'(0));
      check($sformatf("L%0d rst mem_addra", L), 32'(mem_addra), 32'(0));
      check($sformatf("L%0d rst mem_dina", L), mem_dina, 32'(0));
      check($sformatf("L%0d rst if_rdata", L), if_rdata, 32'(0));
      rst = 1'b0;

      do_if(7'd5);
      check($sformatf("L%0d if read 5", L), if_rdata, 32'hDEADBEEF);
      do_dm(1'b1, 7'h7F, 32'h12345678);
      do_dm(1'b0, 7'h7F, 32'h0);
      check($sformatf("L%0d dm read 7f", L), dm_rdata, 32'h12345678);

      // Mixed random traffic on a small address window
      fork
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_if(AW'($urandom_range(0, 15)));
        end
        repeat (40) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          do_dm(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                $urandom);
        end
      join

      // DM burst alone, then fetch joins while DM keeps asking
      fork
        repeat (10)
          do_dm(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                $urandom);
        repeat (3) begin
          repeat (5 * (LAT + 2)) @(negedge clk);
          do_if(AW'($urandom_range(0, 15)));
        end
      join

      // Back-to-back on both ports
      fork
        repeat (12) do_if(AW'($urandom_range(0, 15)));
        repeat (12)
          do_dm(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                $urandom);
      join

      // Reset while a DM read sits in WAIT
      repeat (5) @(negedge clk);
      dm_we   = 1'b0;
      dm_addr = AW'($urandom_range(0, 15));
      dm_req  = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!mem_ena && n < 20);
      check($sformatf("L%0d issue before rst", L), 32'(mem_ena), 32'(1));
      @(negedge clk);
      rst    = 1'b1;
      dm_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check($sformatf("L%0d post-rst ena", L), 32'(mem_ena), 32'(0));
      check($sformatf("L%0d post-rst dm_rdata", L), dm_rdata, 32'(0));
      check($sformatf("L%0d post-rst if_rdata", L), if_rdata, 32'(0));
      repeat (LAT + 4) @(negedge clk);
      do_if(7'd9);
      check($sformatf("L%0d if after rst", L), if_rdata, mmem[9]);
      repeat (3) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin : main
    int n;
    n = 0;
    while (!(g_lane[0].fin && g_lane[1].fin) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50000) begin
      checks++;
      errors++;
      $display("FAIL global timeout: got %0d cycles expected completion", n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
